score_counter: RTL and testbench
================================

// Module: score_counter
// PURPOSE
//   Game score keeper feeding score_render. Counts points in BCD while a run is
//   active, paced by the 20 Hz game tick. Freezes on crash and keeps a high score
//   across runs. Exposes one selected digit per cycle for the renderer's glyph lookup.
// PARAMETERS
//   DIGITS          4  number of BCD digits in score and high score (1..8)
//   TICKS_PER_POINT 2  game ticks per +1 point (>=1)
//   MILESTONE_DIG   2  milestone pulse fires when the low MILESTONE_DIG digits roll to 0
// PORTS
//   clk                 in   1            system clock (pixel clock domain)
//   rst                 in   1            synchronous, active-high reset
//   i_game_tick         in   1            1-cycle pulse, 20 Hz game tick
//   i_game_start_pulse  in   1            1-cycle pulse from player_controller
//   i_game_over_pulse   in   1            1-cycle pulse from player_controller (crash)
//   i_show_hi           in   1            1 = read port returns high score, 0 = score
//   i_digit_sel         in   3            digit index, 0 = least significant
//   o_digit             out  4            registered BCD digit for score_render
//   o_score_bcd         out  4*DIGITS     current score, packed BCD
//   o_hi_bcd            out  4*DIGITS     high score, packed BCD
//   o_running           out  1            1 while in RUN
//   o_new_hi            out  1            1 while in OVER if the last run set a new high
//   o_milestone_pulse   out  1            1-cycle pulse on milestone rollover
// BEHAVIOUR
// - FSM IDLE/RUN/OVER. On rst: IDLE. All outputs and registers are 0, including the prescaler.
// - IDLE: start -> RUN. Score, prescaler and o_new_hi clear in the same edge. over is ignored.
// - RUN: on tick, prescaler++. When prescaler == TICKS_PER_POINT-1, prescaler <= 0 and the
//   score increments by 1 with BCD ripple carry (each digit 0..9).
// - Saturation: at all-9s the score holds. No wrap. The prescaler keeps running.
// - Milestone: when an increment makes the low MILESTONE_DIG digits all 0, o_milestone_pulse
//   asserts for the cycle after that edge. It never fires at reset, on clear, or while saturated.
// - RUN, over -> OVER. The score freezes. If score > hi (unsigned compare of the packed BCD,
//   which is numerically valid), hi <= score and o_new_hi <= 1 on the same edge.
// - Simultaneous over + tick: over wins. There is no increment, and the compare uses the
//   pre-tick score.
// - RUN: start is ignored (no restart mid-run).
// - Simultaneous start + over in RUN: over wins.
// - OVER: start -> RUN. Score, prescaler and o_new_hi clear. hi is retained. over is ignored.
// - rst in any state, including mid-run: return to IDLE with everything 0. hi is also lost.
// - o_running = (state == RUN), registered with the state.
// - Read port: o_digit <= selected digit of (i_show_hi ? hi : score), 1-cycle latency.
//   If i_digit_sel >= DIGITS, o_digit <= 0.
// - o_score_bcd and o_hi_bcd are direct register outputs (0 latency after the edge).
// - Ticks and pulses arriving in IDLE/OVER have no effect on the score.
// TESTING
// 1. rst, then start, then 10 ticks (TICKS_PER_POINT=2) -> score 0005, o_running=1, no milestone.
// 2. Preload a run to 0099, then 2 ticks -> score 0100, o_milestone_pulse high exactly 1 cycle.
// 3. Run to 0042, then over -> o_hi_bcd=0042, o_new_hi=1. Then start + run to 0030 + over
//    -> hi stays 0042, o_new_hi=0.
// 4. Run to 9999, then 20 more ticks -> score stays 9999, no milestone pulse, no wrap to 0000.
// 5. At score 0007 with prescaler=1: tick and over in the same cycle -> score 0007, state OVER,
//    hi 0007.
// 6. Score 0123, hi 0456: sel=1, show_hi=0 -> o_digit=2 one cycle later. show_hi=1 -> 5.
//    sel=5 -> 0. rst mid-run -> all 0, IDLE.

Source files
------------

// File: rtl/score_counter.sv
// score_counter: BCD game score keeper for score_render.
//   Counts points while a run is active, paced by the game tick through a
//   prescaler. The score freezes on crash, a high score is kept across runs,
//   and one selected digit is exposed each cycle for glyph lookup.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_game_tick         1-cycle game tick pulse
//   i_game_start_pulse  start a run (from IDLE or OVER)
//   i_game_over_pulse   crash: end the run
//   i_show_hi           read port source: 1 = high score, 0 = score
//   i_digit_sel         read port digit index (0 = least significant)
//   o_digit             registered selected BCD digit (1-cycle latency)
//   o_score_bcd         current score, packed BCD
//   o_hi_bcd            high score, packed BCD
//   o_running           1 while in RUN
//   o_new_hi            1 in OVER when the last run set a new high
//   o_milestone_pulse   1-cycle pulse when the low digits roll over to 0

// One BCD digit of the increment chain.
module score_digit_inc (
  input  logic [3:0] d,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);
  assign cout = cin && (d == 4'd9);
  assign q    = !cin ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
endmodule

module score_counter #(
  parameter int DIGITS          = 4,
  parameter int TICKS_PER_POINT = 2,
  parameter int MILESTONE_DIG   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_game_tick,
  input  logic                  i_game_start_pulse,
  input  logic                  i_game_over_pulse,
  input  logic                  i_show_hi,
  input  logic [2:0]            i_digit_sel,
  output logic [3:0]            o_digit,
  output logic [4*DIGITS-1:0]   o_score_bcd,
  output logic [4*DIGITS-1:0]   o_hi_bcd,
  output logic                  o_running,
  output logic                  o_new_hi,
  output logic                  o_milestone_pulse
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
  localparam int MD = (MILESTONE_DIG > DIGITS) ? DIGITS :
                      (MILESTONE_DIG < 1) ? 1 : MILESTONE_DIG;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    score, hi, score_inc;
  logic [PW-1:0]   pre;
  logic [DIGITS:0] carry;
  logic            clr_run, end_run, tick_run;
  logic            pre_wrap, inc, low_zero;
  logic [W-1:0]    rd_src;
  logic [3:0]      rd_digit;

  // Ripple +1 across the digits. A carry out of the top digit only happens
  // when every digit is 9, so it doubles as the saturation flag.
  assign carry[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    score_digit_inc u_inc (
      .d    (score[4*g +: 4]),
      .cin  (carry[g]),
      .q    (score_inc[4*g +: 4]),
      .cout (carry[g+1])
    );
  end

  assign pre_wrap = (pre == PW'(TICKS_PER_POINT - 1));
  assign inc      = tick_run && pre_wrap && !carry[DIGITS];
  assign low_zero = (score_inc[4*MD-1:0] == '0);

  // Next state; over takes priority over tick and start inside RUN.
  always_comb begin
    state_d  = state_q;
    clr_run  = 1'b0;
    end_run  = 1'b0;
    tick_run = 1'b0;
    case (state_q)
      IDLE: if (i_game_start_pulse) begin state_d = RUN; clr_run = 1'b1; end
      RUN: begin
        if (i_game_over_pulse) begin
          state_d = OVER;
          end_run = 1'b1;
        end else if (i_game_tick) begin
          tick_run = 1'b1;
        end
      end
      OVER: if (i_game_start_pulse) begin state_d = RUN; clr_run = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  // Read port mux; out-of-range digit indices read as 0.
  always_comb begin
    rd_src   = i_show_hi ? hi : score;
    rd_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (i_digit_sel == 3'(i)) rd_digit = rd_src[4*i +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      score             <= '0;
      hi                <= '0;
      pre               <= '0;
      o_running         <= 1'b0;
      o_new_hi          <= 1'b0;
      o_milestone_pulse <= 1'b0;
      o_digit           <= 4'd0;
    end else begin
      state_q           <= state_d;
      o_running         <= (state_d == RUN);
      o_milestone_pulse <= inc && low_zero;
      o_digit           <= rd_digit;
      if (clr_run) begin
        score    <= '0;
        pre      <= '0;
        o_new_hi <= 1'b0;
      end else if (end_run) begin
        // Packed BCD compares correctly as a plain unsigned number.
        if (score > hi) begin
          hi       <= score;
          o_new_hi <= 1'b1;
        end
      end else if (tick_run) begin
        pre <= pre_wrap ? '0 : pre + PW'(1);
        if (inc) score <= score_inc;
      end
    end
  end

  assign o_score_bcd = score;
  assign o_hi_bcd    = hi;
endmodule

// File: tb/tb_score_counter.sv
module tb_score_counter;
  localparam int DIGITS = 4;
  localparam int TPP    = 2;
  localparam int MIL    = 2;
  localparam int MAXV   = 9999;

  logic        clk = 1'b0;
  logic        rst, tick, start, over, show_hi;
  logic [2:0]  sel;
  logic [3:0]  o_digit;
  logic [15:0] o_score_bcd, o_hi_bcd;
  logic        o_running, o_new_hi, o_milestone_pulse;

  always #5 clk = ~clk;

  score_counter #(.DIGITS(DIGITS), .TICKS_PER_POINT(TPP), .MILESTONE_DIG(MIL)) dut (
    .clk(clk), .rst(rst), .i_game_tick(tick), .i_game_start_pulse(start),
    .i_game_over_pulse(over), .i_show_hi(show_hi), .i_digit_sel(sel),
    .o_digit(o_digit), .o_score_bcd(o_score_bcd), .o_hi_bcd(o_hi_bcd),
    .o_running(o_running), .o_new_hi(o_new_hi), .o_milestone_pulse(o_milestone_pulse)
  );

  typedef struct {
    logic [15:0] score, hi;
    logic        running, new_hi, mil;
    logic [3:0]  digit;
  } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;

  // Reference model: plain integers, game-level rules.
  int m_state = 0;  // 0 idle, 1 run, 2 over
  int m_score = 0, m_hi = 0, m_pre = 0, m_digit = 0;
  bit m_newhi = 0, m_mil = 0;

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int dig(int v, int s);
    if (s >= DIGITS) return 0;
    for (int i = 0; i < s; i++) v = v / 10;
    return v % 10;
  endfunction

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endfunction

  task automatic model(bit r, bit t, bit s, bit o, bit sh, int sl);
    if (r) begin
      m_state = 0; m_score = 0; m_hi = 0; m_pre = 0;
      m_newhi = 0; m_mil = 0; m_digit = 0;
      return;
    end
    m_digit = dig(sh ? m_hi : m_score, sl);
    m_mil = 0;
    case (m_state)
      0, 2: if (s) begin m_state = 1; m_score = 0; m_pre = 0; m_newhi = 0; end
      1: begin
        if (o) begin
          m_state = 2;
          if (m_score > m_hi) begin m_hi = m_score; m_newhi = 1; end
        end else if (t) begin
          m_pre++;
          if (m_pre == TPP) begin
            m_pre = 0;
            if (m_score < MAXV) begin
              m_score++;
              m_mil = (m_score % (10 ** MIL)) == 0;
            end
          end
        end
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic cyc(bit r, bit t, bit s, bit o, bit sh = 0, int sl = 0);
    exp_t e;
    rst = r; tick = t; start = s; over = o; show_hi = sh; sel = 3'(sl);
    model(r, t, s, o, sh, sl);
    @(posedge clk);
    e.score = to_bcd(m_score); e.hi = to_bcd(m_hi);
    e.running = (m_state == 1); e.new_hi = m_newhi; e.mil = m_mil;
    e.digit = 4'(m_digit);
    sb.push_back(e);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
  endtask

  // Monitor: DUT presents a fresh output set after every edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("score",     32'(o_score_bcd),       32'(e.score));
      chk("hi",        32'(o_hi_bcd),          32'(e.hi));
      chk("running",   32'(o_running),         32'(e.running));
      chk("new_hi",    32'(o_new_hi),          32'(e.new_hi));
      chk("milestone", 32'(o_milestone_pulse), 32'(e.mil));
      chk("digit",     32'(o_digit),           32'(e.digit));
    end
  end

  initial begin
    rst = 1; tick = 0; start = 0; over = 0; show_hi = 0; sel = 0;
    repeat (3) cyc(1, 0, 0, 0);
    // idle: ticks and over ignored
    cyc(0, 1, 0, 1); cyc(0, 1, 0, 0);
    // basic count: 10 ticks -> 0005
    cyc(0, 0, 1, 0); ticks(10); cyc(0, 0, 0, 0);
    // milestone at 0099 -> 0100
    cyc(0, 0, 0, 1); cyc(0, 0, 1, 0); ticks(198); ticks(2); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    // high score: 42 sets new high, 30 does not
    cyc(1, 0, 0, 0); cyc(0, 0, 1, 0); ticks(84); cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1); cyc(0, 0, 1, 0); ticks(60); cyc(0, 0, 1, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    // read port: score 0123, hi 0456
    cyc(1, 0, 0, 0); cyc(0, 0, 1, 0); ticks(912); cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0); ticks(246);
    cyc(0, 0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 1, 5); cyc(0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1, 2);
    cyc(0, 0, 0, 0, 0, 3); cyc(0, 0, 0, 0, 0, 7); cyc(0, 0, 0, 0, 0, 2);
    // reset mid-run
    ticks(5); cyc(1, 1, 0, 0); cyc(0, 0, 0, 0, 0, 1);
    // tick + over together at 0007, prescaler 1
    cyc(0, 0, 1, 0); ticks(15); cyc(0, 1, 0, 1); cyc(0, 1, 0, 0, 1, 0);
    // saturation at 9999
    cyc(1, 0, 0, 0); cyc(0, 0, 1, 0); ticks(19998); ticks(20);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0, 1, 3);
    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)));
    cyc(0, 0, 0, 0);
    @(negedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
